shape_cfg_arbiter: RTL

SHAPE_CFG_ARBITER -- requirements
Module: shape_cfg_arbiter

---
 rtl/shape_cfg_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shape_cfg_arbiter.sv
// Two-requester round-robin arbiter that writes a ctrl SFR word to the shape processor and reports the result.
// Optional readback/compare stage is enabled by defining SHAPE_CFG_ARBITER_READBACK_EN.
module shape_cfg_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  done,
  output logic [1:0]  status,
  output logic        busy,
  output logic [7:0]  reject_cnt,
  output logic        write,
  output logic [31:0] write_data,
  output logic        read,
  input  logic [31:0] read_data,
  input  logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    CHK,
`ifdef SHAPE_CFG_ARBITER_READBACK_EN
    RD,
    CMP,
`endif
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_REJECTED = 2'b01,
    ST_MISMATCH = 2'b10
  } status_t;

  state_t      state_q, state_d;
  status_t     result_q, result_d;
  logic        ptr_q;
  logic        grant_q;
  logic [31:0] data_q;
  logic [7:0]  reject_cnt_q;
  logic        win;
  logic        grant_en;

  // The pointed requester wins when it is asking; otherwise the other one must be.
  assign win      = req[ptr_q] ? ptr_q : ~ptr_q;
  assign grant_en = (state_q == IDLE) && (req != 2'b00);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (req != 2'b00) state_d = WR;
      WR:   state_d = CHK;
      CHK: begin
        if (error) begin
          result_d = ST_REJECTED;
          state_d  = RESP;
        end else begin
`ifdef SHAPE_CFG_ARBITER_READBACK_EN
          state_d  = RD;
`else
          result_d = ST_OK;
          state_d  = RESP;
`endif
        end
      end
`ifdef SHAPE_CFG_ARBITER_READBACK_EN
      RD:   state_d = CMP;
      CMP: begin
        result_d = (read_data == data_q) ? ST_OK : ST_MISMATCH;
        state_d  = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      result_q     <= ST_OK;
      ptr_q        <= 1'b0;
      grant_q      <= 1'b0;
      data_q       <= '0;
      reject_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (grant_en) begin
        grant_q <= win;
        data_q  <= win ? req_data1 : req_data0;
      end
      if (state_q == RESP) begin
        ptr_q <= ~grant_q;
        if (result_q != ST_OK && reject_cnt_q != 8'hFF)
          reject_cnt_q <= reject_cnt_q + 8'd1;
      end
    end
  end

  // Strobes decode straight from the state register, so reset clears them at once.
  always_comb begin
    write      = (state_q == WR);
    write_data = (state_q == WR) ? data_q : '0;
    busy       = (state_q != IDLE);
    done       = 2'b00;
    status     = ST_OK;
    if (state_q == RESP) begin
      done   = grant_q ? 2'b10 : 2'b01;
      status = result_q;
    end
  end

`ifdef SHAPE_CFG_ARBITER_READBACK_EN
  assign read = (state_q == RD);
`else
  // Without readback the processor read-back bus has no consumer.
  logic unused_read_data;
  assign unused_read_data = ^read_data;
  assign read             = 1'b0;
`endif

  assign reject_cnt = reject_cnt_q;

endmodule
